// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO UART/counter controller.
//   - MMIO_* : register offsets decoded on addr[7:0]
//   - STAT_* : bit positions inside the STATUS register
//   - pack_status() : assembles the STATUS word from its fields
package mmio_pkg;

    localparam logic [7:0] MMIO_STATUS  = 8'h00;
    localparam logic [7:0] MMIO_RX      = 8'h04;
    localparam logic [7:0] MMIO_TX      = 8'h08;
    localparam logic [7:0] MMIO_CYC_LO  = 8'h10;
    localparam logic [7:0] MMIO_INST_LO = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST = 8'h18;
    localparam logic [7:0] MMIO_CYC_HI  = 8'h1C;
    localparam logic [7:0] MMIO_INST_HI = 8'h20;

    localparam int STAT_TX_NFULL   = 0;
    localparam int STAT_RX_NEMPTY  = 1;
    localparam int STAT_TX_DROP    = 2;
    localparam int STAT_RX_CNT_LSB = 8;
    localparam int STAT_TX_CNT_LSB = 16;

    function automatic logic [31:0] pack_status(
        input logic       tx_nfull,
        input logic       rx_nempty,
        input logic       drop,
        input logic [7:0] rx_cnt,
        input logic [7:0] tx_cnt
    );
        logic [31:0] s;
        s = 32'h0000_0000;
        s[STAT_TX_NFULL]             = tx_nfull;
        s[STAT_RX_NEMPTY]            = rx_nempty;
        s[STAT_TX_DROP]              = drop;
        s[STAT_RX_CNT_LSB +: 8]      = rx_cnt;
        s[STAT_TX_CNT_LSB +: 8]      = tx_cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head output.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, din       : write request and data; ignored while full
//   pop             : remove head; ignored while empty
//   dout            : current head, 0 while empty
//   full, empty     : status flags
//   count           : occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == (AW+1)'(0));
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    // Head is forced to 0 when empty so the storage needs no reset.
    assign dout      = empty ? WIDTH'(0) : r_mem[r_rd_ptr];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= (AW+1)'(0);
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped I/O block beside the data memory.
//   clk, rst_n               : clock, asynchronous active-low reset
//   addr, wdata, we, re      : execute-stage access (full-word stores only)
//   rdata                    : registered read data, one-cycle latency
//   inst_retired             : one pulse per retired instruction
//   rx_data/rx_valid/rx_ready: byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready: byte stream to the UART transmitter
// Contains the address decode, read mux, CYCLE/INSTRET counters and the
// sticky tx_drop flag; buffering lives in two sync_fifo instances.
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 w_sel;
    logic [7:0]           w_off;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_rx_pop;
    logic                 w_tx_push;
    logic                 w_cnt_clr;
    logic                 w_drop_clr;
    logic [7:0]           w_rx_dout;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic [CW-1:0]        w_rx_count;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic [CW-1:0]        w_tx_count;
    logic [31:0]          w_cyc_hi;
    logic [31:0]          w_inst_hi;
    logic [31:0]          w_rdata_mux;
    logic                 w_unused;
    logic [CNT_WIDTH-1:0] r_cycle;
    logic [CNT_WIDTH-1:0] r_instret;
    logic                 r_tx_drop;
    logic [31:0]          r_rdata;

    assign w_sel      = (addr[31:28] == IO_BASE[31:28]);
    assign w_off      = addr[7:0];
    assign w_rd       = re && w_sel;
    assign w_wr       = we && w_sel;
    assign w_rx_pop   = w_rd && (w_off == MMIO_RX);
    assign w_tx_push  = w_wr && (w_off == MMIO_TX);
    assign w_cnt_clr  = w_wr && (w_off == MMIO_CNT_RST);
    assign w_drop_clr = w_wr && (w_off == MMIO_STATUS) && wdata[STAT_TX_DROP];
    assign w_unused   = ^{addr[27:8], wdata[31:8]};

    assign rx_ready = !w_rx_full;
    assign tx_valid = !w_tx_empty;
    assign rdata    = r_rdata;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .pop   (tx_ready),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    generate
        if (CNT_WIDTH > 32) begin : g_hi
            assign w_cyc_hi  = 32'(r_cycle[CNT_WIDTH-1:32]);
            assign w_inst_hi = 32'(r_instret[CNT_WIDTH-1:32]);
        end else begin : g_no_hi
            assign w_cyc_hi  = 32'h0000_0000;
            assign w_inst_hi = 32'h0000_0000;
        end
    endgenerate

    // Read mux; unmapped offsets and the write-only ones return 0.
    always_comb begin
        w_rdata_mux = 32'h0000_0000;
        case (w_off)
            MMIO_STATUS:  w_rdata_mux = pack_status(!w_tx_full, !w_rx_empty, r_tx_drop,
                                                    8'(w_rx_count), 8'(w_tx_count));
            MMIO_RX:      w_rdata_mux = {24'h00_0000, w_rx_dout};
            MMIO_CYC_LO:  w_rdata_mux = r_cycle[31:0];
            MMIO_INST_LO: w_rdata_mux = r_instret[31:0];
            MMIO_CYC_HI:  w_rdata_mux = w_cyc_hi;
            MMIO_INST_HI: w_rdata_mux = w_inst_hi;
            default:      w_rdata_mux = 32'h0000_0000;
        endcase
    end

    // Read data register: captured only on a selected load, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_rd) begin
            r_rdata <= w_rdata_mux;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Cycle and retired-instruction counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= CNT_WIDTH'(0);
            r_instret <= CNT_WIDTH'(0);
        end else if (w_cnt_clr) begin
            r_cycle   <= CNT_WIDTH'(0);
            r_instret <= CNT_WIDTH'(0);
        end else begin
            r_cycle   <= r_cycle + CNT_WIDTH'(1);
            r_instret <= r_instret + CNT_WIDTH'(inst_retired);
        end
    end

    // Sticky flag recording a TX store that found the FIFO full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_drop <= 1'b0;
        end else if (w_tx_push && w_tx_full) begin
            r_tx_drop <= 1'b1;
        end else if (w_drop_clr) begin
            r_tx_drop <= 1'b0;
        end else begin
            r_tx_drop <= r_tx_drop;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed bench with a queue-based reference model that
// is compared against the DUT outputs every cycle, plus literal checks.
module tb_mmio_uart_ctrl;
    import mmio_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    logic        m_drop = 1'b0;
    logic [63:0] m_cyc = 64'h0;
    logic [63:0] m_ins = 64'h0;
    logic [31:0] m_rdata = 32'h0;

    mmio_uart_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .IO_BASE(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .inst_retired(inst_retired),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of the reference model, from the inputs seen at the edge.
    task automatic model_step();
        logic       sel, rd, wr;
        logic [7:0] off;
        int         rxn, txn;
        logic [31:0] v;
        sel = (addr[31:28] == 4'h8);
        off = addr[7:0];
        rd  = re && sel;
        wr  = we && sel;
        rxn = m_rxq.size();
        txn = m_txq.size();
        v   = 32'h0;
        if (off == MMIO_STATUS)
            v = (txn << 16) | (rxn << 8) | (int'(m_drop) << 2)
              | ((rxn != 0) ? 2 : 0) | ((txn != DEPTH) ? 1 : 0);
        else if (off == MMIO_RX)      v = (rxn > 0) ? {24'h0, m_rxq[0]} : 32'h0;
        else if (off == MMIO_CYC_LO)  v = m_cyc[31:0];
        else if (off == MMIO_INST_LO) v = m_ins[31:0];
        else if (off == MMIO_CYC_HI)  v = m_cyc[63:32];
        else if (off == MMIO_INST_HI) v = m_ins[63:32];
        if (rd) m_rdata = v;
        if (rd && off == MMIO_RX && rxn > 0) void'(m_rxq.pop_front());
        if (rx_valid && rxn < DEPTH) m_rxq.push_back(rx_data);
        if (tx_ready && txn > 0) void'(m_txq.pop_front());
        if (wr && off == MMIO_TX) begin
            if (txn == DEPTH) m_drop = 1'b1;
            else m_txq.push_back(wdata[7:0]);
        end
        if (wr && off == MMIO_STATUS && wdata[2]) m_drop = 1'b0;
        if (wr && off == MMIO_CNT_RST) begin
            m_cyc = 64'h0;
            m_ins = 64'h0;
        end else begin
            m_cyc = m_cyc + 64'd1;
            m_ins = m_ins + {63'h0, inst_retired};
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rxq.delete();
            m_txq.delete();
            m_drop  = 1'b0;
            m_cyc   = 64'h0;
            m_ins   = 64'h0;
            m_rdata = 32'h0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, well after the edge.
    initial forever begin
        @(posedge clk);
        #2;
        check("rdata", {32'h0, rdata}, {32'h0, m_rdata});
        check("rx_ready", {63'h0, rx_ready}, (m_rxq.size() < DEPTH) ? 64'd1 : 64'd0);
        check("tx_valid", {63'h0, tx_valid}, (m_txq.size() > 0) ? 64'd1 : 64'd0);
        check("tx_data", {56'h0, tx_data}, (m_txq.size() > 0) ? {56'h0, m_txq[0]} : 64'h0);
    end

    function automatic logic [31:0] io(input logic [7:0] off);
        return 32'h8000_0000 | {24'h0, off};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0; addr = 32'h0;
        d = rdata;
    endtask

    task automatic rx_inject(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  cap[$];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_ready", {63'h0, rx_ready}, 64'd1);
        check("rst_tx_valid", {63'h0, tx_valid}, 64'd0);
        check("rst_rdata", {32'h0, rdata}, 64'h0);
        rst_n = 1'b1;
        bus_read(io(MMIO_STATUS), d);
        check("status_reset", {32'h0, d}, 64'h1);
        bus_read(io(MMIO_CYC_LO), d);
        check("cycle_early", (d >= 32'd1 && d <= 32'd3) ? 64'd1 : 64'd0, 64'd1);

        // TX fill past depth with the transmitter stalled
        for (int i = 0; i < 9; i++) bus_write(io(MMIO_TX), 32'h41 + i);
        bus_read(io(MMIO_STATUS), d);
        check("status_tx_full", {32'h0, d}, 64'h0008_0004);
        bus_write(io(MMIO_STATUS), 32'h0);
        bus_read(io(MMIO_STATUS), d);
        check("drop_kept", {32'h0, d}, 64'h0008_0004);
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (tx_valid) cap.push_back(tx_data);
            @(negedge clk);
        end
        check("tx_count", cap.size(), 64'd8);
        for (int i = 0; i < cap.size(); i++) check("tx_order", {56'h0, cap[i]}, 64'h41 + i);
        bus_write(io(MMIO_STATUS), 32'h4);
        bus_read(io(MMIO_STATUS), d);
        check("drop_clr", {32'h0, d}, 64'h1);

        // RX path
        rx_inject(8'h55);
        rx_inject(8'hAA);
        bus_read(io(MMIO_STATUS), d);
        check("status_rx2", {32'h0, d}, 64'h0000_0203);
        bus_read(io(MMIO_RX), d);
        check("rx_first", {32'h0, d}, 64'h55);
        bus_read(io(MMIO_RX), d);
        check("rx_second", {32'h0, d}, 64'hAA);
        bus_read(io(MMIO_RX), d);
        check("rx_empty_read", {32'h0, d}, 64'h0);
        bus_read(io(MMIO_STATUS), d);
        check("status_rx0", {32'h0, d}, 64'h1);

        // Simultaneous push and pop at occupancy 3
        rx_inject(8'h11); rx_inject(8'h22); rx_inject(8'h33);
        rx_data = 8'h44; rx_valid = 1'b1;
        bus_read(io(MMIO_RX), d);
        rx_valid = 1'b0;
        check("rx_simul", {32'h0, d}, 64'h11);
        bus_read(io(MMIO_STATUS), d);
        check("status_rx3", {32'h0, d}, 64'h0000_0303);
        for (int i = 0; i < 3; i++) begin
            bus_read(io(MMIO_RX), d);
            check("rx_simul_order", {32'h0, d}, 64'h22 + 64'(i) * 64'h11);
        end

        // RX fill to depth
        for (int i = 0; i < DEPTH; i++) rx_inject(8'h60 + 8'(i));
        check("rx_ready_full", {63'h0, rx_ready}, 64'd0);
        rx_inject(8'h7F);
        bus_read(io(MMIO_STATUS), d);
        check("status_rx8", {32'h0, d}, 64'h0000_0803);
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(io(MMIO_RX), d);
            check("rx_drain", {32'h0, d}, 64'h60 + i);
        end

        // Counters: carry into the high word, then clear against a retire pulse
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFD;
        m_cyc = 64'h0000_0000_FFFF_FFFD;
        #1;
        release dut.r_cycle;
        @(negedge clk);
        repeat (4) @(negedge clk);
        bus_read(io(MMIO_CYC_HI), d);
        check("cycle_carry", {32'h0, d}, 64'h1);
        inst_retired = 1'b1;
        repeat (5) @(negedge clk);
        inst_retired = 1'b0;
        bus_read(io(MMIO_INST_LO), d);
        check("instret_nonzero", (d != 32'h0) ? 64'd1 : 64'd0, 64'd1);
        inst_retired = 1'b1;
        bus_write(io(MMIO_CNT_RST), 32'h0);
        inst_retired = 1'b0;
        bus_read(io(MMIO_INST_LO), d);
        check("instret_clr", {32'h0, d}, 64'h0);
        bus_read(io(MMIO_CYC_HI), d);
        check("cycle_hi_clr", {32'h0, d}, 64'h0);

        // Decode boundaries: unselected accesses and unmapped offsets
        tx_ready = 1'b0;
        bus_read(io(MMIO_STATUS), d);
        bus_read(32'h0000_0004, d);
        check("unsel_hold", {32'h0, d}, 64'h1);
        bus_write(32'h1000_0008, 32'h99);
        bus_read(io(8'h0C), d);
        check("unmapped", {32'h0, d}, 64'h0);
        bus_read(io(MMIO_STATUS), d);
        check("unsel_write", {32'h0, d}, 64'h1);

        // Reset in the middle of pending TX traffic
        for (int i = 0; i < 3; i++) bus_write(io(MMIO_TX), 32'hC0 + i);
        bus_read(io(MMIO_STATUS), d);
        check("status_tx3", {32'h0, d}, 64'h0003_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx_valid", {63'h0, tx_valid}, 64'd0);
        check("rst_async_tx_data", {56'h0, tx_data}, 64'h0);
        check("rst_async_rdata", {32'h0, rdata}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(io(MMIO_STATUS), d);
        check("status_after_rst", {32'h0, d}, 64'h1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_ctrl.md
# mmio_uart_ctrl

Memory-mapped I/O controller for the pipelined RV32I core, sitting beside the data memory on the execute-stage address path. It decodes the I/O region, buffers UART receive and transmit bytes in parametrised FIFOs between the core and the existing `uart_receiver` and `uart_transmitter`, and maintains cycle and retired-instruction counters. Read data is registered, so it reaches write-back with the same one-cycle latency as the synchronous data memory.

## Interface
- `FIFO_DEPTH`, 8: entries per UART FIFO; power of two, 2..128.
- `CNT_WIDTH`, 32: counter width, 32..64.
- `IO_BASE`, 32'h8000_0000: base address of the I/O region; bits [31:28] are decoded.

- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 32: byte address from the ALU result.
- `wdata` in 32: store data.
- `we` in 1: store strobe. Byte enables are ignored; every store is a full word.
- `re` in 1: load strobe.
- `rdata` out 32: registered read data.
- `inst_retired` in 1: one-cycle pulse per retired instruction.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: byte stream from `uart_receiver`.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: byte stream to `uart_transmitter`.

## Operation
- Select condition: `addr[31:28] == IO_BASE[31:28]`. Register offsets are decoded on `addr[7:0]`. Unmapped offsets read 0 and ignore writes.
- Offset 0x00, STATUS (read):
  - bit0: tx FIFO not full.
  - bit1: rx FIFO not empty.
  - bit2: `tx_drop` sticky flag.
  - [15:8]: rx occupancy.
  - [23:16]: tx occupancy.
  - All other bits 0.
- Offset 0x00, write: if `wdata[2]` = 1, clear `tx_drop`.
- Offset 0x04, RX_DATA (read): returns the rx FIFO head zero-extended to 32 bits, and pops it. If the FIFO is empty, returns 0 and does not pop.
- Offset 0x08, TX_DATA (write): pushes `wdata[7:0]`. If the FIFO is full, the byte is discarded and `tx_drop` is set.
- Offsets 0x10 and 0x14: CYCLE[31:0] and INSTRET[31:0].
- Offsets 0x1C and 0x20: CYCLE and INSTRET high words, bits [CNT_WIDTH-1:32], zero-extended. They read 0 when `CNT_WIDTH` = 32.
- Offset 0x18, write: clears both counters.
- `rx_ready` = rx FIFO not full. A byte is pushed on `rx_valid && rx_ready`.
- `tx_valid` = tx FIFO not empty, and `tx_data` = tx FIFO head. The head is popped on `tx_valid && tx_ready`.
- CYCLE increments every cycle. INSTRET increments on each `inst_retired` pulse. Both wrap modulo 2^CNT_WIDTH.
- Simultaneous events:
  - Counter clear and increment in the same cycle: the clear wins, and the counter holds 0 after the edge.
  - Push and pop on a non-empty FIFO: occupancy is unchanged.
  - Push on a full FIFO: never occurs on rx, because `rx_ready` is low when full. On tx, the push is discarded and `tx_drop` is set.
  - Pop on an empty FIFO: no state change.
- A FIFO pointer wraps from `FIFO_DEPTH`-1 to 0. Occupancy width is log2(`FIFO_DEPTH`)+1.

## Timing
- `rdata` is registered: it is the value of the addressed register at the edge where `re` is sampled, visible on the following cycle. It holds until the next selected read and is 0 out of reset.
- An RX_DATA read pops at the same edge that captures `rdata`.
- Writes take effect at the edge where `we` is sampled. A STATUS read in the next cycle reflects them.
- No stalls: every access completes in one cycle.
- Reset values:
  - `rdata` = 0, `rx_ready` = 1, `tx_valid` = 0, `tx_data` = 0.
  - Both FIFOs empty, counters 0, `tx_drop` = 0.
- Reset asserted mid-transfer empties both FIFOs immediately, without waiting for a clock edge. Bytes in flight are lost.

## Structure
- Shared package `mmio_pkg` holds the offset constants (`MMIO_STATUS`, `MMIO_RX`, `MMIO_TX`, `MMIO_CYC_LO`, `MMIO_INST_LO`, `MMIO_CNT_RST`, `MMIO_CYC_HI`, `MMIO_INST_HI`) and the STATUS bit positions.
- Sub-module `sync_fifo`, instantiated twice:
  - Parameters `WIDTH`, `DEPTH`.
  - Ports `push`, `pop`, `din`, `dout` (head, combinational), `full`, `empty`, `count`.
  - Asynchronous active-low reset.
- Top level contains the decode, read mux, counters and `tx_drop`.

## Test plan
- Reset release: STATUS reads 0x0000_0001, `rx_ready` = 1, `tx_valid` = 0, and CYCLE reads 1–3 a few cycles later.
- TX fill with `FIFO_DEPTH` = 8 and `tx_ready` = 0:
  - 9 writes of 0x41..0x49: STATUS[23:16] = 8, bit0 = 0, bit2 = 1. Byte 0x49 is absent from the output stream.
  - Release `tx_ready`: 0x41..0x48 emerge in order.
  - Write 0x4 to STATUS: bit2 reads 0.
- RX path:
  - Inject 0x55 then 0xAA: STATUS bit1 = 1 and [15:8] = 2. Two RX_DATA reads return 0x55 then 0xAA.
  - A third read returns 0 with no underflow.
  - Fill to 8: `rx_ready` drops low.
- Simultaneous rx push and RX_DATA pop at occupancy 3: occupancy stays 3, and data order is preserved.
- Counters with `CNT_WIDTH` = 64:
  - Preload CYCLE near 2^32 (force or long run): the carry is visible in the high word at 0x1C.
  - Clear write at 0x18 coinciding with an `inst_retired` pulse: INSTRET reads 0 afterwards.
- Mid-stream `rst_n` pulse while 3 tx bytes are pending: `tx_valid` falls immediately, and STATUS reads 0x0000_0001 after release.
